// File: rtl/slice_serial_adder_ctrl_pkg.sv
// Shared types and defaults for the slice-serial adder controller.
package slice_serial_adder_ctrl_pkg;

    localparam int SLICE_W_DEF    = 4;
    localparam int NUM_SLICES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W_DEF = cnt_w(NUM_SLICES_DEF);

endpackage

// File: rtl/slice_serial_adder_ctrl_rca_slice.sv
// Narrow combinational ripple-carry slice.
// c_msb exposes the carry into the top bit for overflow detection.
module rca_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co    = c[W];
    assign c_msb = c[W-1];

endmodule

// File: rtl/slice_serial_adder_ctrl.sv
// Sequences one narrow adder slice over several cycles, LSB slice first,
// to add or subtract wide operands with a registered inter-slice carry.
module slice_serial_adder_ctrl
    import slice_serial_adder_ctrl_pkg::*;
#(
    parameter int SLICE_W    = SLICE_W_DEF,
    parameter int NUM_SLICES = NUM_SLICES_DEF,
    localparam int W         = SLICE_W * NUM_SLICES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int CW = cnt_w(NUM_SLICES);

    state_t             state;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       res;
    logic [W-1:0]       res_nxt;
    logic [CW-1:0]      cnt;
    logic               carry;
    logic [SLICE_W-1:0] s;
    logic               co;
    logic               c_msb;
    logic               last;

    rca_slice #(
        .W(SLICE_W)
    ) u_slice (
        .x    (a_q[SLICE_W-1:0]),
        .y    (b_q[SLICE_W-1:0]),
        .ci   (carry),
        .s    (s),
        .co   (co),
        .c_msb(c_msb)
    );

    assign last = (cnt == CW'(NUM_SLICES - 1));

    always_comb begin
        res_nxt = res;
        res_nxt[int'(cnt)*SLICE_W +: SLICE_W] = s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                RUN: begin
                    res   <= res_nxt;
                    carry <= co;
                    a_q   <= a_q >> SLICE_W;
                    b_q   <= b_q >> SLICE_W;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        sum   <= res_nxt;
                        cout  <= co;
                        ovf   <= co ^ c_msb;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= DONE;
                    end
                end
                default: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= sub ? ~b : b;
                        carry <= sub | cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
